vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 172 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Pixel-timing master for the VGA output path. Divides clk into a one-clk
//   pixel tick (en), runs the horizontal/vertical raster counters, takes back
//   the colour the draw modules register one clk after en, and produces
//   aligned, blanked RGB plus active-low syncs for the connector.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   hpos, vpos   raster position, stable for CLK_DIV clks
//   en           pixel tick, one clk in every CLK_DIV
//   in_color     registered colour from the draw modules, RRRGGGBB
//   red/green/blue  pixel colour, forced to 0 outside the active area
//   hsync, vsync active-low syncs, zero skew to the colour they belong to
//   frame_start  one-clk pulse after the counters wrap to (0,0)
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       en,
  input  logic [7:0] in_color,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [1:0] blue,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Divider and raster counters
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             en_q, en_d;
  logic [9:0]       hpos_q, hpos_d;
  logic [9:0]       vpos_q, vpos_d;

  // Alignment stage: region flags of the pixel just ticked
  logic             act_al_q, act_al_d;
  logic             hs_al_q, hs_al_d;
  logic             vs_al_q, vs_al_d;
  logic             tick_q, tick_d;

  // Output registers
  logic [7:0]       rgb_q, rgb_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             frame_start_q, frame_start_d;

  // Region decode of the current position
  logic             h_wrap, v_wrap;
  logic             active, hsync_raw, vsync_raw;

  always_comb begin
    h_wrap    = (hpos_q == H_LAST);
    v_wrap    = (vpos_q == V_LAST);
    active    = (hpos_q < H_ACT) && (vpos_q < V_ACT);
    hsync_raw = !((hpos_q >= H_SYNC_BEG) && (hpos_q < H_SYNC_END));
    vsync_raw = !((vpos_q >= V_SYNC_BEG) && (vpos_q < V_SYNC_END));
  end

  // en is registered from the next divider value so it is a clean flop
  // output, low in reset and held high from the first edge when CLK_DIV=1.
  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    en_d      = (div_cnt_d == DIV_LAST);
  end

  always_comb begin
    hpos_d = hpos_q;
    vpos_d = vpos_q;
    if (en_q) begin
      hpos_d = h_wrap ? '0 : hpos_q + 1'b1;
      if (h_wrap) begin
        vpos_d = v_wrap ? '0 : vpos_q + 1'b1;
      end
    end
  end

  // Flags are captured from the pre-increment position on the en edge, the
  // same edge on which the draw modules sample hpos/vpos.
  always_comb begin
    act_al_d      = act_al_q;
    hs_al_d       = hs_al_q;
    vs_al_d       = vs_al_q;
    tick_d        = en_q;
    frame_start_d = en_q && h_wrap && v_wrap;
    if (en_q) begin
      act_al_d = active;
      hs_al_d  = hsync_raw;
      vs_al_d  = vsync_raw;
    end
  end

  // One clk after the tick in_color belongs to the captured pixel, so colour
  // and syncs are registered together for zero skew.
  always_comb begin
    rgb_d   = rgb_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    if (tick_q) begin
      rgb_d   = act_al_q ? in_color : '0;
      hsync_d = hs_al_q;
      vsync_d = vs_al_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q     <= '0;
      en_q          <= 1'b0;
      hpos_q        <= '0;
      vpos_q        <= '0;
      act_al_q      <= 1'b0;
      hs_al_q       <= 1'b1;
      vs_al_q       <= 1'b1;
      tick_q        <= 1'b0;
      rgb_q         <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      en_q          <= en_d;
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      act_al_q      <= act_al_d;
      hs_al_q       <= hs_al_d;
      vs_al_q       <= vs_al_d;
      tick_q        <= tick_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign en          = en_q;
  assign red         = rgb_q[7:5];
  assign green       = rgb_q[4:2];
  assign blue        = rgb_q[1:0];
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default timing at CLK_DIV=2 and
// CLK_DIV=1, and a tiny 15x11 raster at CLK_DIV=3 so whole frames fit in the
// run). A closed-form model derives every output from the number of clk edges
// since reset release; directed checks pin that model to literal values.
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] hp [3];
  logic [9:0] vp [3];
  logic       en_w [3];
  logic [2:0] rd [3];
  logic [2:0] gr [3];
  logic [1:0] bl [3];
  logic       hs [3];
  logic       vs [3];
  logic       fs [3];
  logic [7:0] col [3];

  int n_cyc;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Edges since reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n_cyc <= 0;
    else        n_cyc <= n_cyc + 1;
  end

  // Draw-module stub: registers hpos[7:0] as colour on each en edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) col[k] <= 8'h00;
    end else begin
      for (int k = 0; k < 3; k++) if (en_w[k]) col[k] <= hp[k][7:0];
    end
  end

  vga_timing_gen #(.CLK_DIV(2)) u0 (
    .clk(clk), .rst_n(rst_n), .hpos(hp[0]), .vpos(vp[0]), .en(en_w[0]),
    .in_color(col[0]), .red(rd[0]), .green(gr[0]), .blue(bl[0]),
    .hsync(hs[0]), .vsync(vs[0]), .frame_start(fs[0]));

  vga_timing_gen #(.CLK_DIV(1)) u1 (
    .clk(clk), .rst_n(rst_n), .hpos(hp[1]), .vpos(vp[1]), .en(en_w[1]),
    .in_color(col[1]), .red(rd[1]), .green(gr[1]), .blue(bl[1]),
    .hsync(hs[1]), .vsync(vs[1]), .frame_start(fs[1]));

  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) u2 (
    .clk(clk), .rst_n(rst_n), .hpos(hp[2]), .vpos(vp[2]), .en(en_w[2]),
    .in_color(col[2]), .red(rd[2]), .green(gr[2]), .blue(bl[2]),
    .hsync(hs[2]), .vsync(vs[2]), .frame_start(fs[2]));

  // Pixels ticked (counter advances) after n edges since release
  function automatic int pix(input int d, input int n);
    if (n <= 0) return 0;
    if (d == 1) return n - 1;
    return n / d;
  endfunction

  // Expected {hpos, vpos, en, rgb, hsync, vsync, frame_start} after n edges
  function automatic logic [31:0] model(input int k, input int n);
    int d, ha, hf, hw, hb, va, vf, vw, vb, ht, vt, p, pp, i, h, v;
    logic act, hsx, vsx, fsx, enx;
    logic [7:0] rgb;
    if (k == 2) begin
      d = 3; ha = 8; hf = 2; hw = 3; hb = 2; va = 6; vf = 1; vw = 2; vb = 2;
    end else begin
      d = (k == 0) ? 2 : 1;
      ha = 640; hf = 16; hw = 96; hb = 48; va = 480; vf = 10; vw = 2; vb = 33;
    end
    ht  = ha + hf + hw + hb;
    vt  = va + vf + vw + vb;
    p   = pix(d, n);
    pp  = pix(d, n - 1);
    enx = (n >= 1) && ((d == 1) || (n % d == d - 1));
    rgb = 8'h00;
    hsx = 1'b1;
    vsx = 1'b1;
    // Outputs show the pixel whose tick preceded the latest edge by one clk
    if (pp >= 1) begin
      i   = pp - 1;
      h   = i % ht;
      v   = (i / ht) % vt;
      act = (h < ha) && (v < va);
      rgb = act ? 8'(h % 256) : 8'h00;
      hsx = !((h >= ha + hf) && (h < ha + hf + hw));
      vsx = !((v >= va + vf) && (v < va + vf + vw));
    end
    fsx = (p != pp) && (p % (ht * vt) == 0);
    return {10'(p % ht), 10'((p / ht) % vt), enx, rgb, hsx, vsx, fsx};
  endfunction

  function automatic logic [31:0] obs(input int k);
    return {hp[k], vp[k], en_w[k], rd[k], gr[k], bl[k], hs[k], vs[k], fs[k]};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, n_cyc);
    end
  endtask

  // Advance one clk and compare every instance against the model
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 3; k++) check($sformatf("model_u%0d", k), obs(k), model(k, n_cyc));
  endtask

  task automatic wait_pix(input int k, input int h, input int v, input int limit, input string name);
    int g;
    g = 0;
    while (!(en_w[k] && hp[k] == 10'(h) && (v < 0 || vp[k] == 10'(v))) && g < limit) begin
      step();
      g++;
    end
    if (g >= limit) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  int cnt, fall1, g;
  int col_h [4]   = '{100, 639, 640, 700};
  int col_exp [4] = '{100, 127, 0, 0};

  initial begin
    // Reset state
    repeat (3) step();
    check("rst_hpos", {22'd0, hp[0]}, 32'd0);
    check("rst_syncs", {30'd0, hs[0], vs[0]}, 32'd3);
    check("rst_en_div1", {31'd0, en_w[1]}, 32'd0);
    #2 rst_n = 1'b1;

    // First ticks after release
    step();
    check("en_edge1_div2", {31'd0, en_w[0]}, 32'd1);
    check("en_edge1_div1", {31'd0, en_w[1]}, 32'd1);
    step();
    check("en_edge2_div2", {31'd0, en_w[0]}, 32'd0);
    check("hpos_edge2_div2", {22'd0, hp[0]}, 32'd1);
    check("hpos_edge2_div1", {22'd0, hp[1]}, 32'd1);

    // hsync placement, width and line period at CLK_DIV=2
    wait_pix(0, 656, -1, 3000, "hs_start");
    step();
    check("hs_fall_not_early", {31'd0, hs[0]}, 32'd1);
    step();
    check("hs_fall_2clk", {31'd0, hs[0]}, 32'd0);
    fall1 = n_cyc;
    cnt = 0;
    g = 0;
    while (hs[0] == 1'b0 && g < 400) begin cnt++; step(); g++; end
    check("hs_width_div2", cnt, 32'd192);
    g = 0;
    while (hs[0] == 1'b1 && g < 2000) begin step(); g++; end
    check("line_period_div2", n_cyc - fall1, 32'd1600);

    // hsync width at CLK_DIV=1
    g = 0;
    while (hs[1] == 1'b0 && g < 1000) begin step(); g++; end
    while (hs[1] == 1'b1 && g < 1000) begin step(); g++; end
    cnt = 0;
    while (hs[1] == 1'b0 && g < 1000) begin cnt++; step(); g++; end
    check("hs_width_div1", cnt, 32'd96);

    // Line wrap (799,10) -> (0,11)
    wait_pix(0, 799, 10, 25000, "line_wrap");
    step();
    check("line_wrap", {12'd0, hp[0], vp[0]}, {12'd0, 10'd0, 10'd11});

    // Colour alignment and horizontal blanking on line 11
    for (int t = 0; t < 4; t++) begin
      wait_pix(0, col_h[t], 11, 2000, "col_wait");
      step();
      step();
      check($sformatf("colour_h%0d", col_h[t]), {24'd0, rd[0], gr[0], bl[0]}, 32'(col_exp[t]));
    end

    // Reset mid-frame on the small raster, then frame restart
    wait_pix(2, 3, 4, 1000, "mid_frame");
    @(posedge clk);
    #3 rst_n = 1'b0;
    step();
    check("midrst_pos", {12'd0, hp[2], vp[2]}, 32'd0);
    check("midrst_out", {24'd0, rd[0], gr[0], bl[0]}, 32'd0);
    check("midrst_sync", {28'd0, hs[2], vs[2], fs[2], en_w[2]}, 32'hc);
    step();
    #2 rst_n = 1'b1;
    cnt = 0;
    g = 0;
    while (fs[2] == 1'b0 && g < 1000) begin
      step();
      if (vs[2] == 1'b0) cnt++;
      g++;
    end
    check("first_frame_start", n_cyc, 32'd495);
    check("vsync_low_clks", cnt, 32'd90);
    step();
    check("frame_start_1clk", {31'd0, fs[2]}, 32'd0);

    // Further frames under the model only
    repeat (1100) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
